// File: rtl/ref_clksw_pkg.sv
// ---------------------------------------------------------------------------
// Module   : ref_clksw_pkg
// Brief    : Shared types and default timing constants for the reference
//            clock switch controller.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ref_clksw_pkg;

  // Controller states; DWELL is only reachable when REF_CLKSW_DWELL_EN is set
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_DWELL  = 2'd2
  } state_e;

  localparam int unsigned C_SETTLE_CYCLES_DEF = 8;
  localparam int unsigned C_DWELL_CYCLES_DEF  = 16;

endpackage

`default_nettype wire

// File: rtl/ref_clksw_timer.sv
// ---------------------------------------------------------------------------
// Module   : ref_clksw_timer
// Brief    : Loadable 8-bit down-counter with zero flag; times both the
//            settle window and the dwell window of the switch controller.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ref_clksw_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Load has priority; decrement saturates at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 8'd0);

endmodule

`default_nettype wire

// File: rtl/ref_clock_switch_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : ref_clock_switch_ctrl
// Brief    : Control FSM for a two-source glitch-free reference clock mux.
//            Handles requested switches, rejects switches to unhealthy
//            sources and performs autonomous failover.
//            Optional macro REF_CLKSW_DWELL_EN adds a post-switch dwell
//            period of DWELL_CYCLES during which no request is accepted.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ref_clock_switch_ctrl
  import ref_clksw_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = C_SETTLE_CYCLES_DEF,
  parameter int unsigned DWELL_CYCLES  = C_DWELL_CYCLES_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic       req_sel_i,
  output logic       req_ready_o,
  output logic       resp_valid_o,
  output logic       resp_err_o,
  input  logic [1:0] src_ok_i,
  output logic       mux_sel_o,
  output logic       cur_sel_o,
  output logic       busy_o,
  output logic       failover_o
);

  localparam logic [7:0] C_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] C_DWELL_LOAD  = 8'(DWELL_CYCLES - 1);

  state_e state_q;
  logic   mux_sel_q;
  logic   cur_sel_q;
  logic   resp_valid_q;
  logic   resp_err_q;
  logic   failover_q;
  logic   fo_run_q;     // current switch is a failover: no completion response

  logic   w_fo_cond;
  logic   w_ready;
  logic   w_fo_start;
  logic   w_req_start;
  logic   w_sw_done;
  logic   w_tmr_zero;
  logic   w_tmr_load;
  logic   [7:0] w_tmr_val;

  // Active source dead while the other is alive
  assign w_fo_cond   = ~src_ok_i[cur_sel_q] & src_ok_i[~cur_sel_q];
  assign w_ready     = (state_q == ST_IDLE) & ~w_fo_cond;
  assign w_fo_start  = (state_q != ST_SWITCH) & w_fo_cond;
  assign w_req_start = w_ready & req_valid_i & (req_sel_i != cur_sel_q) & src_ok_i[req_sel_i];
  assign w_sw_done   = (state_q == ST_SWITCH) & w_tmr_zero;

`ifdef REF_CLKSW_DWELL_EN
  // Timer reload: settle window on switch start, dwell window on completion
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = C_SETTLE_LOAD;
    if (w_fo_start || w_req_start) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = C_SETTLE_LOAD;
    end else if (w_sw_done) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = C_DWELL_LOAD;
    end
  end
`else
  logic w_unused_dwell;
  assign w_unused_dwell = ^C_DWELL_LOAD;

  // Timer reload: settle window on switch start only
  always_comb begin
    w_tmr_load = w_fo_start | w_req_start;
    w_tmr_val  = C_SETTLE_LOAD;
  end
`endif

  ref_clksw_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .dec_i      (state_q != ST_IDLE),
    .zero_o     (w_tmr_zero)
  );

  // Switch sequencing FSM with registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      mux_sel_q    <= 1'b0;
      cur_sel_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      failover_q   <= 1'b0;
      fo_run_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      failover_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_fo_cond) begin
            state_q    <= ST_SWITCH;
            mux_sel_q  <= ~cur_sel_q;
            failover_q <= 1'b1;
            fo_run_q   <= 1'b1;
          end else if (req_valid_i) begin
            if (req_sel_i == cur_sel_q) begin
              resp_valid_q <= 1'b1;
            end else if (!src_ok_i[req_sel_i]) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q   <= ST_SWITCH;
              mux_sel_q <= req_sel_i;
              fo_run_q  <= 1'b0;
            end
          end
        end
        ST_SWITCH: begin
          if (w_tmr_zero) begin
            cur_sel_q    <= mux_sel_q;
            resp_valid_q <= ~fo_run_q;
`ifdef REF_CLKSW_DWELL_EN
            state_q      <= ST_DWELL;
`else
            state_q      <= ST_IDLE;
`endif
          end
        end
`ifdef REF_CLKSW_DWELL_EN
        ST_DWELL: begin
          if (w_fo_cond) begin
            state_q    <= ST_SWITCH;
            mux_sel_q  <= ~cur_sel_q;
            failover_q <= 1'b1;
            fo_run_q   <= 1'b1;
          end else if (w_tmr_zero) begin
            state_q <= ST_IDLE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = w_ready & ~rst_i;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign mux_sel_o    = mux_sel_q;
  assign cur_sel_o    = cur_sel_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign failover_o   = failover_q;

endmodule

`default_nettype wire

// File: tb/tb_ref_clock_switch_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : tb_ref_clock_switch_ctrl
// Brief    : Randomized self-checking bench for ref_clock_switch_ctrl with a
//            timestamp-based reference model. Honours REF_CLKSW_DWELL_EN.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ref_clock_switch_ctrl;

  localparam int C_SETTLE = 8;
`ifdef REF_CLKSW_DWELL_EN
  localparam int C_DWELL = 16;
`else
  localparam int C_DWELL = 0;
`endif
  localparam int C_CYCLES = 4000;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_sel;
  logic [1:0] src_ok;
  logic       req_ready;
  logic       resp_valid;
  logic       resp_err;
  logic       mux_sel;
  logic       cur_sel;
  logic       busy;
  logic       failover;

  int n_checks = 0;
  int n_errors = 0;

  ref_clock_switch_ctrl u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_sel_i    (req_sel),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_err_o   (resp_err),
    .src_ok_i     (src_ok),
    .mux_sel_o    (mux_sel),
    .cur_sel_o    (cur_sel),
    .busy_o       (busy),
    .failover_o   (failover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Reference model: events kept as absolute cycle timestamps
  int n             = 0;
  int sw_done_at    = -1;  // cycle in which cur_sel takes the new value
  int dwell_free_at = -1;  // first cycle requests may be taken again
  int resp_at       = -1;
  int fo_at         = -1;
  int mux_at        = -1;
  bit m_cur, m_mux, mux_val, sw_target, m_err;
  bit switching, dwelling, idle, fo;

  task automatic start_switch(input bit target, input bit is_fo);
    sw_target     = target;
    mux_val       = target;
    mux_at        = n + 1;
    sw_done_at    = n + 1 + C_SETTLE;
    dwell_free_at = sw_done_at + C_DWELL;
    if (is_fo) begin
      fo_at = n + 1;
    end else begin
      resp_at = sw_done_at;
      m_err   = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_cur = 0; m_mux = 0; m_err = 0;
      sw_done_at = -1; dwell_free_at = -1; resp_at = -1; fo_at = -1; mux_at = -1;
      check_eq("rst_mux_sel",    mux_sel,    1'b0);
      check_eq("rst_cur_sel",    cur_sel,    1'b0);
      check_eq("rst_req_ready",  req_ready,  1'b0);
      check_eq("rst_resp_valid", resp_valid, 1'b0);
      check_eq("rst_resp_err",   resp_err,   1'b0);
      check_eq("rst_busy",       busy,       1'b0);
      check_eq("rst_failover",   failover,   1'b0);
    end else begin
      if (n == mux_at)     m_mux = mux_val;
      if (n == sw_done_at) m_cur = sw_target;
      switching = (n < sw_done_at);
      dwelling  = (n >= sw_done_at) && (n < dwell_free_at);
      idle      = !switching && !dwelling;
      fo        = !src_ok[m_cur] && src_ok[!m_cur];

      check_eq("mux_sel",    mux_sel,              m_mux);
      check_eq("cur_sel",    cur_sel,              m_cur);
      check_eq("busy",       busy,                 !idle);
      check_eq("req_ready",  req_ready,            idle && !fo);
      check_eq("resp_valid", resp_valid,           resp_at == n);
      check_eq("resp_err",   resp_valid & resp_err, (resp_at == n) && m_err);
      check_eq("failover",   failover,             fo_at == n);

      if (!switching && fo) begin
        start_switch(!m_cur, 1'b1);
      end else if (idle && req_valid) begin
        if (req_sel == m_cur) begin
          resp_at = n + 1; m_err = 1'b0;
        end else if (!src_ok[req_sel]) begin
          resp_at = n + 1; m_err = 1'b1;
        end else begin
          start_switch(req_sel, 1'b0);
        end
      end
    end
    n++;
  end

  task automatic drive(input bit r, input bit v, input bit s, input logic [1:0] ok);
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_sel = s; src_ok = ok;
  endtask

  initial begin
    int sel;
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0; src_ok = 2'b11;
    repeat (3) @(posedge clk);
    // Clean switch to B, then same-source and rejected requests
    drive(0, 0, 0, 2'b11);
    drive(0, 1, 1, 2'b11);
    drive(0, 0, 0, 2'b11);
    repeat (C_SETTLE + C_DWELL + 2) drive(0, 0, 0, 2'b11);
    drive(0, 1, 1, 2'b11);
    drive(0, 0, 0, 2'b10);
    drive(0, 1, 0, 2'b10);
    drive(0, 0, 0, 2'b10);
    // Failover back to A with a request pending
    drive(0, 1, 1, 2'b01);
    repeat (C_SETTLE + C_DWELL + 2) drive(0, 1, 1, 2'b01);
    // Back-to-back requests, then reset three cycles into a switch
    drive(0, 1, 1, 2'b11);
    repeat (C_SETTLE + C_DWELL + 4) drive(0, 1, 0, 2'b11);
    drive(0, 1, 1, 2'b11);
    repeat (3) drive(0, 0, 0, 2'b11);
    drive(1, 0, 0, 2'b11);
    drive(0, 0, 0, 2'b11);
    // Both sources dead: no failover, switch requests error
    drive(0, 1, 1, 2'b00);
    drive(0, 1, 1, 2'b00);
    drive(0, 0, 0, 2'b11);

    for (int i = 0; i < C_CYCLES; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: src_ok = 2'b00;
          1: src_ok = 2'b01;
          2: src_ok = 2'b10;
          default: src_ok = 2'b11;
        endcase
      end
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0,
            1'($urandom_range(0, 1)), src_ok);
    end
    drive(0, 0, 0, 2'b11);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
